fp_mult_seq_ctrl: RTL and testbench

- Sequenced IEEE-754 single-precision multiplier.
- Accepts one operand pair over a valid/ready handshake.
- Screens special operands, then drives an iterative shift-add mantissa datapath one partial product per clock.
- Normalizes, applies round-to-nearest-even and holds the result until the consumer accepts it.
- Serves as the area-cheap, multi-cycle counterpart to the combinational fp multiplier, for blocks that can tolerate latency.

---
 rtl/fp_mult_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_fp_mult_seq_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq_ctrl.sv
// Sequenced IEEE-754 binary32 multiplier. It takes one operand pair over a
// valid/ready handshake and screens special operands, which resolve in one
// cycle. Other operands go through a 24-step shift-add mantissa multiply,
// then normalization and round-to-nearest-even. The result is held until
// the consumer accepts it.
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   f_1, f_2             operands A and B, sampled on the handshake
//   out_valid/out_ready  result handshake; s and flags held while stalled
//   s                    product {sign, exp, mantissa}
//   f_nan, f_inf, f_zero result class flags
//   f_ovf, f_unf         finite overflow to inf / nonzero flush to zero
module fp_mult_seq_ctrl #(
    parameter int unsigned N    = 24,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] f_1,
    input  logic [31:0] f_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        f_nan,
    output logic        f_inf,
    output logic        f_zero,
    output logic        f_ovf,
    output logic        f_unf
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = 5;
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t          state, state_next;
    logic            sign;
    logic [7:0]      ea, eb;
    logic [PW-1:0]   mcand, acc;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   cnt;

    logic [31:0]     s_next;
    logic            nan_next, inf_next, zero_next, ovf_next, unf_next;
    logic            out_valid_next;

    // Operand classification; exponent 0 means zero (denormals flushed).
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic sp_nan, sp_inf, sp_zero, special;
    logic sign_in;

    always_comb begin
        a_zero  = (f_1[30:23] == 8'h00);
        a_inf   = (f_1[30:23] == 8'hFF) && (f_1[22:0] == 23'd0);
        a_nan   = (f_1[30:23] == 8'hFF) && (f_1[22:0] != 23'd0);
        b_zero  = (f_2[30:23] == 8'h00);
        b_inf   = (f_2[30:23] == 8'hFF) && (f_2[22:0] == 23'd0);
        b_nan   = (f_2[30:23] == 8'hFF) && (f_2[22:0] != 23'd0);
        sign_in = f_1[31] ^ f_2[31];
        sp_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        sp_inf  = a_inf || b_inf;
        sp_zero = a_zero || b_zero;
        special = sp_nan || sp_inf || sp_zero;
    end

    // Normalize and round the finished 48-bit product.
    logic [EW-1:0] e_base, e_norm, e_fin;
    logic [22:0]   mant_raw;
    logic          g, st, round_up;
    logic [23:0]   rnd;
    logic          n_ovf, n_unf;
    logic [31:0]   n_s;

    always_comb begin
        e_base = EW'({2'b00, ea}) + EW'({2'b00, eb}) - EW'(127);
        if (acc[PW-1]) begin
            mant_raw = acc[46:24];
            g        = acc[23];
            st       = |acc[22:0];
            e_norm   = e_base + EW'(1);
        end else begin
            mant_raw = acc[45:23];
            g        = acc[22];
            st       = |acc[21:0];
            e_norm   = e_base;
        end
        round_up = g && (st || mant_raw[0]);
        rnd      = {1'b0, mant_raw} + 24'(round_up);
        // A carry out of the mantissa leaves rnd[22:0] at zero: bump exponent.
        e_fin    = e_norm + EW'(rnd[23]);
        n_ovf    = !e_fin[EW-1] && (e_fin >= EW'(255));
        n_unf    = e_fin[EW-1] || (e_fin == EW'(0));
        if (n_ovf)      n_s = {sign, 8'hFF, 23'd0};
        else if (n_unf) n_s = {sign, 31'd0};
        else            n_s = {sign, e_fin[7:0], rnd[22:0]};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        s_next         = s;
        nan_next       = f_nan;
        inf_next       = f_inf;
        zero_next      = f_zero;
        ovf_next       = f_ovf;
        unf_next       = f_unf;
        out_valid_next = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        state_next     = DONE;
                        out_valid_next = 1'b1;
                        if (sp_nan) begin
                            s_next   = QNAN;
                            nan_next = 1'b1;
                        end else if (sp_inf) begin
                            s_next   = {sign_in, 8'hFF, 23'd0};
                            inf_next = 1'b1;
                        end else begin
                            s_next    = {sign_in, 31'd0};
                            zero_next = 1'b1;
                        end
                    end else begin
                        state_next = MULT;
                    end
                end
            end
            MULT: begin
                if (cnt == CW'(N - 1)) state_next = NORM;
            end
            NORM: begin
                state_next     = DONE;
                out_valid_next = 1'b1;
                s_next         = n_s;
                inf_next       = n_ovf;
                ovf_next       = n_ovf;
                zero_next      = n_unf;
                unf_next       = n_unf;
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                    nan_next       = 1'b0;
                    inf_next       = 1'b0;
                    zero_next      = 1'b0;
                    ovf_next       = 1'b0;
                    unf_next       = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= 32'd0;
            f_nan     <= 1'b0;
            f_inf     <= 1'b0;
            f_zero    <= 1'b0;
            f_ovf     <= 1'b0;
            f_unf     <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= out_valid_next;
            s         <= s_next;
            f_nan     <= nan_next;
            f_inf     <= inf_next;
            f_zero    <= zero_next;
            f_ovf     <= ovf_next;
            f_unf     <= unf_next;
        end
    end

    // Shift-add datapath: the multiplicand shifts left and the multiplier
    // shifts right, so step cnt adds (multiplicand << cnt) when bit cnt is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign   <= 1'b0;
            ea     <= 8'd0;
            eb     <= 8'd0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign   <= sign_in;
                        ea     <= f_1[30:23];
                        eb     <= f_2[30:23];
                        acc    <= '0;
                        mcand  <= PW'({1'b1, f_1[22:0]});
                        mplier <= {1'b1, f_2[22:0]};
                        cnt    <= '0;
                    end
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Directed self-checking bench for fp_mult_seq_ctrl: result values, flags,
// latency, backpressure hold and mid-operation reset.
module tb_fp_mult_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] f_1, f_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        f_nan, f_inf, f_zero, f_ovf, f_unf;

    int checks   = 0;
    int failures = 0;

    // Flag order: {nan, inf, zero, ovf, unf}
    localparam logic [4:0] FL_NONE = 5'b00000;
    localparam logic [4:0] FL_NAN  = 5'b10000;
    localparam logic [4:0] FL_INF  = 5'b01000;
    localparam logic [4:0] FL_ZERO = 5'b00100;
    localparam logic [4:0] FL_OVF  = 5'b01010;
    localparam logic [4:0] FL_UNF  = 5'b00101;

    always #5 clk = ~clk;

    fp_mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_1       (f_1),
        .f_2       (f_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .f_nan     (f_nan),
        .f_inf     (f_inf),
        .f_zero    (f_zero),
        .f_ovf     (f_ovf),
        .f_unf     (f_unf)
    );

    function automatic logic [4:0] flags();
        return {f_nan, f_inf, f_zero, f_ovf, f_unf};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One complete transaction with out_ready held high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic [4:0] exp_f,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        f_1       = a;
        f_2       = b;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".s"}, s, exp_s);
        chk({tag, ".flags"}, 32'(flags()), 32'(exp_f));
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, ".drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".clr"}, 32'(flags()), 32'(FL_NONE));
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] s_hold;
        logic [4:0]  f_hold;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        f_1       = 32'd0;
        f_2       = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.s", s, 32'd0);
        chk("rst.flags", 32'(flags()), 32'(FL_NONE));
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, FL_NONE, 26);
        run_op("tie_rnd",     32'h3FC00000, 32'h3F800001, 32'h3FC00002, FL_NONE, 26);
        run_op("no_rnd",      32'h3F800001, 32'h3F800001, 32'h3F800002, FL_NONE, 26);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, FL_NAN,  1);
        run_op("ninf_x_2",    32'hFF800000, 32'h40000000, 32'hFF800000, FL_INF,  1);
        run_op("nzero_x_1",   32'h80000000, 32'h3F800000, 32'h80000000, FL_ZERO, 1);
        run_op("nan_x_1",     32'h7F800001, 32'h3F800000, 32'h7FC00000, FL_NAN,  1);
        run_op("ovf",         32'h7F000000, 32'h7F000000, 32'h7F800000, FL_OVF,  26);
        run_op("unf",         32'h00800000, 32'h00800000, 32'h00000000, FL_UNF,  26);
        run_op("neg_mix",     32'hC0000000, 32'h40400000, 32'hC0C00000, FL_NONE, 26);

        // Backpressure: hold result for 10 cycles; a stray in_valid is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        f_1      = 32'h3FC00000;
        f_2      = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("bp.latency", 32'(lat), 32'd26);
        chk("bp.s", s, 32'h40400000);
        s_hold = s;
        f_hold = flags();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.hold_s", s, s_hold);
            chk("bp.hold_flags", 32'(flags()), 32'(f_hold));
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            if (i == 3) begin
                in_valid = 1'b1;
                f_1      = 32'h7F800000;
                f_2      = 32'h00000000;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.drop", 32'(out_valid), 32'd0);
        chk("bp.idle", 32'(in_ready), 32'd1);
        run_op("bp.next", 32'h40000000, 32'h40000000, 32'h40800000, FL_NONE, 26);

        // Reset in the middle of MULT discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        f_1      = 32'h40000000;
        f_2      = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mrst.quiet", 32'(out_valid), 32'd0);
        end
        run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, FL_NONE, 26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
